regfile_wr_arbiter: RTL and testbench

//  Round-robin arbiter and sequencer for the CPU register bank's single write port.
//  The bank is NREG 8-bit negedge-capture registers with En/Cen/Rst.
//  Up to NREQ units (ALU, load, immediate) request writes; one winner per cycle.

---
 rtl/regfile_wr_arbiter_if.sv | 26 ++
 rtl/regfile_wr_arbiter.sv | 121 ++++++++++++
 tb/tb_regfile_wr_arbiter.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/regfile_wr_arbiter_if.sv
// Write-request bus between the register-bank writers and the write-port arbiter.
// The master side is the set of requesters. The slave side is the arbiter, which drives the bank enables and data.
interface regfile_wr_arbiter_if #(
  parameter int NREQ = 3,
  parameter int NREG = 8,
  parameter int DW   = 8,
  parameter int AW   = 3
);
  logic [NREQ-1:0]    Req;
  logic [NREQ*AW-1:0] ReqAddr;
  logic [NREQ*DW-1:0] ReqData;
  logic [NREQ-1:0]    Gnt;
  logic [NREG-1:0]    WrEn;
  logic [DW-1:0]      WrData;
  logic               ErrAddr;

  modport master (
    output Req, ReqAddr, ReqData,
    input  Gnt, WrEn, WrData, ErrAddr
  );

  modport slave (
    input  Req, ReqAddr, ReqData,
    output Gnt, WrEn, WrData, ErrAddr
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter for the register bank's single write port. Its outputs are registered on posedge for negedge capture.
// Define RFARB_ZERO_REG_EN to hardwire register 0 to zero, which never enables WrEn[0].
module regfile_wr_arbiter #(
  parameter int NREQ = 3,
  parameter int NREG = 8,
  parameter int DW   = 8,
  parameter int AW   = 3
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Cen,
  regfile_wr_arbiter_if.slave   bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

`ifdef RFARB_ZERO_REG_EN
  localparam bit ZeroRegEn = 1'b1;
`else
  localparam bit ZeroRegEn = 1'b0;
`endif

  logic [0:0]      state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   last_q, last_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREG-1:0] wr_en_q, wr_en_d;
  logic [DW-1:0]   wr_data_q, wr_data_d;
  logic            err_q, err_d;

  logic [NREQ-1:0] elig;
  logic            win_found;
  logic [PW-1:0]   win_idx;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_data;
  logic [NREG-1:0] win_dec;
  logic            win_oor;

  // Arbitration: mask last winner while it drops Req, then search from ptr.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    elig = bus.Req;
    if (state_q == GRANT) elig[last_q] = 1'b0;

    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!win_found && elig[(int'(ptr_q) + i) % NREQ]) begin
        win_found = 1'b1;
        win_idx   = PW'((int'(ptr_q) + i) % NREQ);
      end
    end

    win_addr = bus.ReqAddr[int'(win_idx)*AW +: AW];
    win_data = bus.ReqData[int'(win_idx)*DW +: DW];
    win_oor  = (int'(win_addr) >= NREG);

    win_dec = '0;
    for (int j = 0; j < NREG; j++) begin
      win_dec[j] = (int'(win_addr) == j);
    end
    if (ZeroRegEn) win_dec[0] = 1'b0;
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    last_d    = last_q;
    gnt_d     = gnt_q;
    wr_en_d   = wr_en_q;
    wr_data_d = wr_data_q;
    err_d     = err_q;

    if (Cen) begin
      if (win_found) begin
        state_d   = GRANT;
        ptr_d     = PW'((int'(win_idx) + 1) % NREQ);
        last_d    = win_idx;
        gnt_d     = NREQ'(1) << win_idx;
        wr_en_d   = win_dec;
        wr_data_d = win_data;
        err_d     = err_q | win_oor;
      end else begin
        state_d = IDLE;
        gnt_d   = '0;
        wr_en_d = '0;
      end
    end
  end

  // Rst is synchronous and takes priority over Cen, so it kills an in-flight grant.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      last_q    <= '0;
      gnt_q     <= '0;
      wr_en_q   <= '0;
      wr_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      err_q     <= err_d;
    end
  end

  assign bus.Gnt     = gnt_q;
  assign bus.WrEn    = wr_en_q;
  assign bus.WrData  = wr_data_q;
  assign bus.ErrAddr = err_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter, with a scoreboard of expected per-cycle outputs and a negedge register-bank model.
// A second instance with NREG=6 covers an out-of-range address.
module tb_regfile_wr_arbiter;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  logic Cen = 1'b1;

  always #5 Clk = ~Clk;

  regfile_wr_arbiter_if #(.NREQ(3), .NREG(8), .DW(8), .AW(3)) bus  ();
  regfile_wr_arbiter_if #(.NREQ(3), .NREG(6), .DW(8), .AW(3)) bus6 ();

  regfile_wr_arbiter #(.NREQ(3), .NREG(8), .DW(8), .AW(3)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .Cen (Cen),
    .bus (bus.slave)
  );

  regfile_wr_arbiter #(.NREQ(3), .NREG(6), .DW(8), .AW(3)) dut6 (
    .Clk (Clk),
    .Rst (Rst),
    .Cen (Cen),
    .bus (bus6.slave)
  );

`ifdef RFARB_ZERO_REG_EN
  localparam bit ZeroReg = 1'b1;
`else
  localparam bit ZeroReg = 1'b0;
`endif

  typedef struct packed {
    logic [2:0] gnt;
    logic [7:0] wr_en;
    logic [7:0] wr_data;
    logic       err;
  } exp_t;

  exp_t sb_q[$];
  int   pass_cnt = 0;
  int   chk_cnt  = 0;

  // Register bank: negedge capture gated by each register's En and Cen.
  logic [7:0] regs [8];
  always @(negedge Clk) begin
    if (Rst) begin
      for (int j = 0; j < 8; j++) regs[j] <= 8'h00;
    end else if (Cen) begin
      for (int j = 0; j < 8; j++) if (bus.WrEn[j]) regs[j] <= bus.WrData;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic expect_out(input logic [2:0] g, input logic [7:0] w,
                            input logic [7:0] d, input logic e);
    exp_t x;
    x.gnt     = g;
    x.wr_en   = w;
    x.wr_data = d;
    x.err     = e;
    sb_q.push_back(x);
  endtask

  // Advance one cycle and compare the DUT outputs against the oldest expectation.
  task automatic tick(input string tag);
    exp_t x;
    @(posedge Clk);
    #1;
    chk({tag, ".sb"}, 32'(sb_q.size() != 0), 32'd1);
    if (sb_q.size() != 0) begin
      x = sb_q.pop_front();
      chk({tag, ".gnt"},  32'(bus.Gnt),     32'(x.gnt));
      chk({tag, ".wren"}, 32'(bus.WrEn),    32'(x.wr_en));
      chk({tag, ".data"}, 32'(bus.WrData),  32'(x.wr_data));
      chk({tag, ".err"},  32'(bus.ErrAddr), 32'(x.err));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.Req = '0;  bus.ReqAddr = '0;  bus.ReqData = '0;
    bus6.Req = '0; bus6.ReqAddr = '0; bus6.ReqData = '0;

    // Reset state
    expect_out(3'b000, 8'h00, 8'h00, 1'b0); tick("rst0");
    expect_out(3'b000, 8'h00, 8'h00, 1'b0); tick("rst1");

    // 1: single write to register 5
    Rst = 1'b0;
    bus.Req = 3'b001; bus.ReqAddr = {3'd0, 3'd0, 3'd5}; bus.ReqData = {8'h00, 8'h00, 8'hA5};
    expect_out(3'b001, 8'h20, 8'hA5, 1'b0); tick("t1_gnt");
    @(negedge Clk); #1;
    chk("t1_reg5", 32'(regs[5]), 32'h0000_00A5);
    bus.Req = 3'b000;
    expect_out(3'b000, 8'h00, 8'hA5, 1'b0); tick("t1_idle");

    // 2: all three requesting, round-robin from a fresh pointer
    Rst = 1'b1;
    expect_out(3'b000, 8'h00, 8'h00, 1'b0); tick("t2_rst");
    Rst = 1'b0;
    bus.Req = 3'b111; bus.ReqAddr = {3'd3, 3'd2, 3'd1}; bus.ReqData = {8'h33, 8'h22, 8'h11};
    expect_out(3'b001, 8'h02, 8'h11, 1'b0); tick("t2_g0");
    expect_out(3'b010, 8'h04, 8'h22, 1'b0); tick("t2_g1");
    expect_out(3'b100, 8'h08, 8'h33, 1'b0); tick("t2_g2");
    expect_out(3'b001, 8'h02, 8'h11, 1'b0); tick("t2_g3");
    expect_out(3'b010, 8'h04, 8'h22, 1'b0); tick("t2_g4");
    bus.Req = 3'b000;
    expect_out(3'b000, 8'h00, 8'h22, 1'b0); tick("t2_idle");

    // 3: lone requester served only every other cycle
    bus.Req = 3'b010; bus.ReqAddr = {3'd0, 3'd4, 3'd0}; bus.ReqData = {8'h00, 8'h44, 8'h00};
    expect_out(3'b010, 8'h10, 8'h44, 1'b0); tick("t3_g0");
    expect_out(3'b000, 8'h00, 8'h44, 1'b0); tick("t3_gap");
    expect_out(3'b010, 8'h10, 8'h44, 1'b0); tick("t3_g1");
    bus.Req = 3'b000;
    expect_out(3'b000, 8'h00, 8'h44, 1'b0); tick("t3_idle");

    // 4: Cen dropped during a grant freezes it; the write lands when Cen returns
    bus.Req = 3'b001; bus.ReqAddr = {3'd0, 3'd0, 3'd6}; bus.ReqData = {8'h00, 8'h00, 8'h66};
    expect_out(3'b001, 8'h40, 8'h66, 1'b0); tick("t4_gnt");
    Cen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      expect_out(3'b001, 8'h40, 8'h66, 1'b0); tick("t4_frz");
    end
    chk("t4_reg6_frozen", 32'(regs[6]), 32'h0);
    Cen = 1'b1;
    @(negedge Clk); #1;
    chk("t4_reg6_done", 32'(regs[6]), 32'h0000_0066);
    bus.Req = 3'b000;
    expect_out(3'b000, 8'h00, 8'h66, 1'b0); tick("t4_idle");

    // 5: pointer kept through the freeze, then Rst kills the grant to requester 1
    bus.Req = 3'b110; bus.ReqAddr = {3'd2, 3'd1, 3'd0}; bus.ReqData = {8'h88, 8'h77, 8'h00};
    expect_out(3'b010, 8'h02, 8'h77, 1'b0); tick("t5_gnt");
    Rst = 1'b1;
    expect_out(3'b000, 8'h00, 8'h00, 1'b0); tick("t5_rst");
    Rst = 1'b0;
    expect_out(3'b010, 8'h02, 8'h77, 1'b0); tick("t5_re1");
    expect_out(3'b100, 8'h04, 8'h88, 1'b0); tick("t5_re2");
    bus.Req = 3'b000;
    expect_out(3'b000, 8'h00, 8'h88, 1'b0); tick("t5_idle");

    // 6: address 0, and an out-of-range address on the NREG=6 instance
    bus.Req = 3'b001; bus.ReqAddr = {3'd0, 3'd0, 3'd0}; bus.ReqData = {8'h00, 8'h00, 8'hFF};
    expect_out(3'b001, ZeroReg ? 8'h00 : 8'h01, 8'hFF, 1'b0); tick("t6_a0");
    @(negedge Clk); #1;
    chk("t6_reg0", 32'(regs[0]), ZeroReg ? 32'h0 : 32'h0000_00FF);
    bus.Req = 3'b000;
    bus6.Req = 3'b001; bus6.ReqAddr = {3'd0, 3'd0, 3'd7}; bus6.ReqData = {8'h00, 8'h00, 8'h5A};
    expect_out(3'b000, 8'h00, 8'hFF, 1'b0); tick("t6_idle");
    chk("t6_oor_gnt",  32'(bus6.Gnt),     32'b001);
    chk("t6_oor_wren", 32'(bus6.WrEn),    32'h0);
    chk("t6_oor_data", 32'(bus6.WrData),  32'h0000_005A);
    chk("t6_oor_err",  32'(bus6.ErrAddr), 32'd1);
    bus6.Req = 3'b000;
    expect_out(3'b000, 8'h00, 8'hFF, 1'b0); tick("t6_idle2");
    chk("t6_oor_gnt0",   32'(bus6.Gnt),     32'b000);
    chk("t6_oor_sticky", 32'(bus6.ErrAddr), 32'd1);
    Rst = 1'b1;
    expect_out(3'b000, 8'h00, 8'h00, 1'b0); tick("t6_rst");
    chk("t6_oor_clr", 32'(bus6.ErrAddr), 32'd0);
    Rst = 1'b0;

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
